fetch_controller: RTL

Instruction-fetch sequencer for the `InstructionMemory` block ROM. It owns the program counter and drives the ROM's enable and address, absorbing the ROM's one-cycle read latency. It delivers PC-tagged instruction words to decode over a valid/ready handshake, and flushes and restarts on branch or jump redirects from the execute stage.

---
 rtl/fetch_pkg.sv | 17 +
 rtl/fetch_fifo.sv | 65 ++++++
 rtl/fetch_controller.sv | 96 +++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch sequencer.
package fetch_pkg;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic {
        IDLE  = 1'b0,
        FETCH = 1'b1
    } state_t;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Two-entry {pc, instr} buffer with a registered head; flush beats push.
// Zero-latency occupancy; the caller must never push when full without a pop.
module fetch_fifo
    import fetch_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  fetch_entry_t push_data,
    input  logic         pop,
    input  logic         flush,
    output logic [1:0]   count,
    output fetch_entry_t head,
    output logic         head_valid
);

    fetch_entry_t slot0;
    fetch_entry_t slot1;
    logic         vld0;
    logic         vld1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot0 <= '0;
            slot1 <= '0;
            vld0  <= 1'b0;
            vld1  <= 1'b0;
        end else if (flush) begin
            vld0 <= 1'b0;
            vld1 <= 1'b0;
        end else begin
            case ({push, pop})
                2'b01: begin
                    slot0 <= slot1;
                    vld0  <= vld1;
                    vld1  <= 1'b0;
                end
                2'b10: begin
                    if (!vld0) begin
                        slot0 <= push_data;
                        vld0  <= 1'b1;
                    end else begin
                        slot1 <= push_data;
                        vld1  <= 1'b1;
                    end
                end
                2'b11: begin
                    // Pop implies slot0 was valid, so it stays valid either way.
                    if (vld1) begin
                        slot0 <= slot1;
                        slot1 <= push_data;
                    end else begin
                        slot0 <= push_data;
                    end
                end
                default: ;
            endcase
        end
    end

    assign count      = {vld0 & vld1, vld0 ^ vld1};
    assign head       = slot0;
    assign head_valid = vld0;

endmodule

// File: rtl/fetch_controller.sv
// PC sequencer for a 1-cycle-latency block ROM; issue to instr_valid is 2 cycles.
// Stops issuing once buffered + in-flight words would exceed 2, so decode stalls never overflow.
module fetch_controller
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          ADDR_W   = 10
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        run,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        rom_en,
    output logic [31:0] rom_addr,
    input  logic [31:0] rom_data,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic        busy
);

    state_t       state;
    state_t       state_nxt;
    logic [31:0]  pc;
    logic         inflight;
    logic [31:0]  inflight_pc;
    logic         issue;
    logic         pop;
    logic         push;
    logic [1:0]   count;
    logic [2:0]   occupancy;
    fetch_entry_t head;
    fetch_entry_t push_data;
    logic         head_valid;

    assign pop       = head_valid & instr_ready;
    assign occupancy = {1'b0, count} + {2'b00, inflight} - {2'b00, pop};

    always_comb begin
        state_nxt = state;
        issue     = 1'b0;
        case (state)
            IDLE: begin
                if (run) state_nxt = FETCH;
            end
            FETCH: begin
                if (!run) state_nxt = IDLE;
                issue = !redirect_valid && (occupancy < 3'd2);
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            pc          <= RESET_PC;
            inflight    <= 1'b0;
            inflight_pc <= '0;
        end else begin
            state    <= state_nxt;
            inflight <= issue;
            if (issue) inflight_pc <= pc;
            if (redirect_valid)
                pc <= {redirect_pc[31:2], 2'b00};
            else if (issue)
                pc <= pc + 32'd4;
        end
    end

    // A redirect squashes the word returning this cycle by withholding its push.
    assign push      = inflight & ~redirect_valid;
    assign push_data = '{pc: inflight_pc, instr: rom_data};

    fetch_fifo u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (push),
        .push_data  (push_data),
        .pop        (pop),
        .flush      (redirect_valid),
        .count      (count),
        .head       (head),
        .head_valid (head_valid)
    );

    assign rom_en      = issue;
    assign rom_addr    = {{(XLEN-ADDR_W){1'b0}}, pc[ADDR_W+1:2]};
    assign instr_valid = head_valid;
    assign instr       = head.instr;
    assign instr_pc    = head.pc;
    assign busy        = inflight | (count != 2'd0);

endmodule
